// File: rtl/spi_slave.sv
// SPI slave, oversampled in the system clock domain. ssel/sclk/mosi are
// synchronised into clk, words shift MSB-first in both directions, and each
// received word is presented with a one-cycle rxRdy strobe.
`timescale 1ns/1ps
module spi_slave #(
  parameter logic        CPOL     = 1'b1,
  parameter logic        CPHA     = 1'b1,
  parameter int unsigned DATA_WDT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ssel,
  input  logic                sclk,
  input  logic                mosi,
  output logic                miso,
  input  logic [DATA_WDT-1:0] txData,
  input  logic                txLoad,
  output logic [DATA_WDT-1:0] rxData,
  output logic                rxRdy
);

  localparam int unsigned     CW       = $clog2(DATA_WDT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DATA_WDT - 1);

  logic [1:0]          ssel_sync;
  logic [1:0]          sclk_sync;
  logic [1:0]          mosi_sync;
  logic                ssel_hist;
  logic                sclk_hist;

  logic                selected;
  logic [CW-1:0]       bit_cnt;
  logic [DATA_WDT-2:0] rx_shift;
  logic [DATA_WDT-1:0] tx_buf;
  logic [DATA_WDT-1:0] tx_shift;

  logic                ssel_fall;
  logic                active;
  logic                leading;
  logic                trailing;
  logic                sample_edge;
  logic                start_word;
  logic                shift_word;
  logic [DATA_WDT-1:0] tx_src;

  // Two-flop synchronisers plus history flops for edge detection.
  // The ssel chain resets low so that an ssel already low when reset
  // releases is not mistaken for a falling edge: a fresh fall is required.
  always_ff @(posedge clk) begin
    if (reset) begin
      ssel_sync <= '0;
      ssel_hist <= 1'b0;
      sclk_sync <= {2{CPOL}};
      sclk_hist <= CPOL;
      mosi_sync <= '0;
    end else begin
      ssel_sync <= {ssel_sync[0], ssel};
      ssel_hist <= ssel_sync[1];
      sclk_sync <= {sclk_sync[0], sclk};
      sclk_hist <= sclk_sync[1];
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  // Edge qualification and per-mode word start / shift decisions.
  always_comb begin
    ssel_fall   = ssel_hist & ~ssel_sync[1];
    active      = ssel_fall | (selected & ~ssel_sync[1]);
    leading     = active & (sclk_hist == CPOL) & (sclk_sync[1] != CPOL);
    trailing    = active & (sclk_hist != CPOL) & (sclk_sync[1] == CPOL);
    sample_edge = CPHA ? trailing : leading;
    tx_src      = txLoad ? txData : tx_buf;
    if (CPHA) begin
      start_word = leading & (bit_cnt == '0);
      shift_word = leading & (bit_cnt != '0);
    end else begin
      start_word = ssel_fall | (trailing & (bit_cnt == '0));
      shift_word = trailing & (bit_cnt != '0);
    end
  end

  // Receive path: shift on each sample edge, publish the word on the last bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      selected <= 1'b0;
      bit_cnt  <= '0;
      rx_shift <= '0;
      rxData   <= '0;
      rxRdy    <= 1'b0;
    end else begin
      selected <= active;
      rxRdy    <= 1'b0;
      if (!active) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (sample_edge) begin
        if (bit_cnt == CNT_LAST) begin
          rxData  <= {rx_shift, mosi_sync[1]};
          rxRdy   <= 1'b1;
          bit_cnt <= '0;
        end else begin
          rx_shift <= (DATA_WDT-1)'({rx_shift, mosi_sync[1]});
          bit_cnt  <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // Transmit path: host-loaded buffer, copied into the shifter at word start.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_buf   <= '0;
      tx_shift <= '0;
    end else begin
      if (txLoad) tx_buf <= txData;
      if (start_word)      tx_shift <= tx_src;
      else if (shift_word) tx_shift <= {tx_shift[DATA_WDT-2:0], 1'b0};
    end
  end

  // selected and tx_shift are both registers, so miso changes only on clk.
  assign miso = selected ? tx_shift[DATA_WDT-1] : 1'bz;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: one instance per SPI mode (index = {CPOL,CPHA}),
// each driven by its own master pins; a pullup shows an undriven miso as 1.
`timescale 1ns/1ps
module tb_spi_slave;

  logic       clk   = 1'b1;
  logic       reset = 1'b1;
  logic [3:0] ssel  = 4'b1111;
  logic [3:0] sclk  = 4'b1100;
  logic [3:0] mosi  = 4'b0000;
  logic [3:0] tx_load = 4'b0000;
  logic [7:0] tx_data [4] = '{default: 8'h00};
  wire  [3:0] miso;
  logic [7:0] rx_data [4];
  logic [3:0] rx_rdy;

  int total = 0;
  int bad   = 0;
  int rdy_cnt [4] = '{default: 0};

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam logic [1:0] MODE = 2'(g);
    pullup (miso[g]);
    spi_slave #(.CPOL(MODE[1]), .CPHA(MODE[0]), .DATA_WDT(8)) dut (
      .clk    (clk),
      .reset  (reset),
      .ssel   (ssel[g]),
      .sclk   (sclk[g]),
      .mosi   (mosi[g]),
      .miso   (miso[g]),
      .txData (tx_data[g]),
      .txLoad (tx_load[g]),
      .rxData (rx_data[g]),
      .rxRdy  (rx_rdy[g])
    );
  end

  always #5 clk = ~clk;

  // Count clk cycles with rxRdy high; a stretched pulse shows up as extra counts.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (rx_rdy[i]) rdy_cnt[i]++;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic load(input int m, input logic [7:0] v);
    @(negedge clk);
    tx_data[m] = v;
    tx_load[m] = 1'b1;
    @(negedge clk);
    tx_load[m] = 1'b0;
  endtask

  task automatic sel(input int m);
    ssel[m] = 1'b0;
    #100;
  endtask

  task automatic desel(input int m);
    #100;
    ssel[m] = 1'b1;
    #200;
  endtask

  // Master side of one word (or its first nbits), 5 MHz sclk.
  task automatic xfer(input int m, input logic [7:0] tx, input int nbits,
                      output logic [7:0] rx);
    logic cpol;
    logic cpha;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (cpha) begin
        sclk[m] = ~cpol;
        mosi[m] = tx[i];
        #100;
        sclk[m] = cpol;
        rx[i]   = miso[m];
        #100;
      end else begin
        mosi[m] = tx[i];
        #100;
        sclk[m] = ~cpol;
        rx[i]   = miso[m];
        #100;
        sclk[m] = cpol;
      end
    end
  endtask

  initial begin
    logic [7:0] r1;
    logic [7:0] r2;
    int c0;

    // Reset state: rx outputs clear, miso released.
    #105 reset = 1'b0;
    repeat (5) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("m%0d_rst_rxdata", m), rx_data[m], 8'h00);
      chk($sformatf("m%0d_rst_rxrdy", m), {7'b0, rx_rdy[m]}, 8'h00);
      chk($sformatf("m%0d_rst_miso_z", m), {7'b0, miso[m]}, 8'h01);
    end

    // Single word in every mode.
    for (int m = 0; m < 4; m++) begin
      load(m, 8'hA5);
      c0 = rdy_cnt[m];
      sel(m);
      xfer(m, 8'h3C, 8, r1);
      desel(m);
      chk($sformatf("m%0d_single_miso", m), r1, 8'hA5);
      chk($sformatf("m%0d_single_rx", m), rx_data[m], 8'h3C);
      chk($sformatf("m%0d_single_rdy", m), 8'(rdy_cnt[m] - c0), 8'd1);
    end

    // Burst of two words, buffer loaded once.
    load(3, 8'h5A);
    c0 = rdy_cnt[3];
    sel(3);
    xfer(3, 8'hFF, 8, r1);
    chk("burst_rx0", rx_data[3], 8'hFF);
    chk("burst_rdy0", 8'(rdy_cnt[3] - c0), 8'd1);
    xfer(3, 8'h01, 8, r2);
    chk("burst_rx1", rx_data[3], 8'h01);
    chk("burst_rdy1", 8'(rdy_cnt[3] - c0), 8'd2);
    desel(3);
    chk("burst_miso0", r1, 8'h5A);
    chk("burst_miso1", r2, 8'h5A);

    // Abort after 5 bits, then a complete word.
    c0 = rdy_cnt[3];
    sel(3);
    xfer(3, 8'hC3, 5, r1);
    desel(3);
    chk("abort_rx", rx_data[3], 8'h01);
    chk("abort_rdy", 8'(rdy_cnt[3] - c0), 8'd0);
    sel(3);
    xfer(3, 8'h81, 8, r1);
    desel(3);
    chk("after_abort_rx", rx_data[3], 8'h81);
    chk("after_abort_rdy", 8'(rdy_cnt[3] - c0), 8'd1);
    chk("after_abort_miso", r1, 8'h5A);

    // sclk noise while deselected.
    for (int m = 0; m < 4; m++) begin
      c0 = rdy_cnt[m];
      for (int k = 0; k < 16; k++) begin
        sclk[m] = ~sclk[m];
        mosi[m] = k[0];
        #100;
        chk($sformatf("m%0d_noise_miso_z%0d", m, k), {7'b0, miso[m]}, 8'h01);
      end
      chk($sformatf("m%0d_noise_rdy", m), 8'(rdy_cnt[m] - c0), 8'd0);
      chk($sformatf("m%0d_noise_rx", m), rx_data[m], (m == 3) ? 8'h81 : 8'h3C);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
